// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants, types and FSM states for the writeback arbiter
// Optional scoreboard is enabled by REGFILE_WB_ARB_SCOREBOARD_EN.
package regfile_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = reg_addr_t'(31);

  typedef enum logic {
    ARB,
    FORCE
  } arb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback sources, hazard lookup and regfile write port bundle
// master drives requests and lookups; slave is the arbiter.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic      wb_valid;
  reg_addr_t wb_addr;
  reg_data_t wb_data;
  logic      mc_valid;
  reg_addr_t mc_addr;
  reg_data_t mc_data;
  logic      mc_ready;
  logic      issue_valid;
  reg_addr_t issue_addr;
  reg_addr_t ra1;
  reg_addr_t ra2;
  logic      busy1;
  logic      busy2;
  logic      stall_pipe;
  logic      we3;
  reg_addr_t wa3;
  reg_data_t wd3;

  modport master (
    output wb_valid, wb_addr, wb_data,
    output mc_valid, mc_addr, mc_data,
    output issue_valid, issue_addr, ra1, ra2,
    input  mc_ready, busy1, busy2, stall_pipe, we3, wa3, wd3
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  mc_valid, mc_addr, mc_data,
    input  issue_valid, issue_addr, ra1, ra2,
    output mc_ready, busy1, busy2, stall_pipe, we3, wa3, wd3
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// rtl/regfile_wb_arbiter_scoreboard.sv - pending-destination vector for long-latency ops
// Only instantiated when REGFILE_WB_ARB_SCOREBOARD_EN is defined.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t ra1,
  input  reg_addr_t ra2,
  output logic      busy1,
  output logic      busy2
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_addr != ZERO_REG)) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
  end

  // Set is applied after clear so a re-issue in the completion cycle stays pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= (pending_q & ~clr_mask) | set_mask;
  end

  assign busy1 = pending_q[ra1];
  assign busy2 = pending_q[ra2];

  a_no_double_issue: assert property (@(posedge clk) disable iff (reset)
    (pending_q & set_mask & ~clr_mask) == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - regfile write-port arbiter: pipeline WB priority, starvation-forced mc grant
// Pending-destination scoreboard is built only under REGFILE_WB_ARB_SCOREBOARD_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                reset,
  regfile_wb_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             mc_ready;
  logic             stall_pipe;
  logic             grant_wb;
  logic             grant_mc;
  reg_addr_t        wr_addr;
  reg_data_t        wr_data;
  logic             we3_q;
  reg_addr_t        wa3_q;
  reg_data_t        wd3_q;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    mc_ready   = 1'b0;
    stall_pipe = 1'b0;
    grant_wb   = 1'b0;
    grant_mc   = 1'b0;
    case (state_q)
      ARB: begin
        mc_ready = !bus.wb_valid;
        grant_wb = bus.wb_valid;
        grant_mc = !bus.wb_valid && bus.mc_valid;
        if (grant_mc)                          wait_d = '0;
        else if (bus.mc_valid && wait_q != LIMIT) wait_d = wait_q + 1'b1;
        // Enter FORCE on the cycle the refusal count reaches the limit.
        if (wait_d == LIMIT) state_d = FORCE;
      end
      FORCE: begin
        stall_pipe = 1'b1;
        mc_ready   = 1'b1;
        grant_mc   = bus.mc_valid;
        wait_d     = '0;
        state_d    = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  assign wr_addr = grant_wb ? bus.wb_addr : bus.mc_addr;
  assign wr_data = grant_wb ? bus.wb_data : bus.mc_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      wait_q  <= '0;
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      we3_q   <= (grant_wb || grant_mc) && (wr_addr != ZERO_REG);
      if (grant_wb || grant_mc) begin
        wa3_q <= wr_addr;
        wd3_q <= wr_data;
      end
    end
  end

  assign bus.mc_ready   = mc_ready;
  assign bus.stall_pipe = stall_pipe;
  assign bus.we3        = we3_q;
  assign bus.wa3        = wa3_q;
  assign bus.wd3        = wd3_q;

`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
  regfile_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (bus.issue_valid),
    .set_addr (bus.issue_addr),
    .clr_en   (bus.mc_valid && mc_ready),
    .clr_addr (bus.mc_addr),
    .ra1      (bus.ra1),
    .ra2      (bus.ra2),
    .busy1    (bus.busy1),
    .busy2    (bus.busy2)
  );
`else
  logic unused_sb;
  assign unused_sb = ^{bus.issue_valid, bus.issue_addr, bus.ra1, bus.ra2};
  assign bus.busy1 = 1'b0;
  assign bus.busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter with write scoreboard queue
// Busy expectations follow REGFILE_WB_ARB_SCOREBOARD_EN.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int LIMIT = 4;

  typedef struct packed {
    logic      we;
    reg_addr_t wa;
    reg_data_t wd;
  } wr_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wr_t       exp_q[$];
  bit        m_force;
  int        m_wait;
  bit [31:0] pend;
  reg_addr_t last_wa;
  reg_data_t last_wd;
  reg_addr_t r1, r2;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_busy(input reg_addr_t a);
`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
    return pend[a];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_force = 1'b0;
    m_wait  = 0;
    pend    = '0;
    last_wa = '0;
    last_wd = '0;
    exp_q.delete();
  endtask

  task automatic drive_cycle(input logic wv, input reg_addr_t wa, input reg_data_t wd,
                             input logic mv, input reg_addr_t ma, input reg_data_t md,
                             input logic iv, input reg_addr_t ia,
                             output logic acc, output logic obs_ready);
    logic exp_ready, hs, wg;
    wr_t  e;
    bus.wb_valid = wv;  bus.wb_addr = wa;  bus.wb_data = wd;
    bus.mc_valid = mv;  bus.mc_addr = ma;  bus.mc_data = md;
    bus.issue_valid = iv; bus.issue_addr = ia;
    bus.ra1 = r1; bus.ra2 = r2;
    #2;
    exp_ready = m_force || !wv;
    check_eq("mc_ready", bus.mc_ready, exp_ready);
    check_eq("stall_pipe", bus.stall_pipe, m_force);
    check_eq("busy1", bus.busy1, exp_busy(r1));
    check_eq("busy2", bus.busy2, exp_busy(r2));
    obs_ready = bus.mc_ready;
    hs = mv && exp_ready;
    wg = wv && !m_force;
    if (wg) begin
      last_wa = wa; last_wd = wd;
    end else if (hs) begin
      last_wa = ma; last_wd = md;
    end
    e.we = (wg || hs) && (last_wa != 5'd31);
    e.wa = last_wa;
    e.wd = last_wd;
    exp_q.push_back(e);
    if (m_force) begin
      m_force = 1'b0;
      m_wait  = 0;
    end else if (hs) begin
      m_wait = 0;
    end else if (mv) begin
      m_wait++;
      if (m_wait == LIMIT) m_force = 1'b1;
    end
    if (hs) pend[ma] = 1'b0;
    if (iv && ia != 5'd31) pend[ia] = 1'b1;
    acc = hs;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("we3", bus.we3, e.we);
    check_eq("wa3", bus.wa3, e.wa);
    check_eq("wd3", bus.wd3, e.wd);
  endtask

  initial begin
    logic      acc, rdy;
    int        refusals;
    logic      mreq;
    reg_addr_t ma, wa, ia;
    reg_data_t md;

    n_checks = 0;
    n_errors = 0;
    r1 = 5'd7;
    r2 = 5'd31;
    reset = 1'b1;
    bus.wb_valid = 0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.mc_valid = 0; bus.mc_addr = '0; bus.mc_data = '0;
    bus.issue_valid = 0; bus.issue_addr = '0;
    bus.ra1 = r1; bus.ra2 = r2;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_we3", bus.we3, 0);
    check_eq("rst_wa3", bus.wa3, 0);
    check_eq("rst_wd3", bus.wd3, 0);
    check_eq("rst_stall", bus.stall_pipe, 0);
    check_eq("rst_busy1", bus.busy1, 0);
    reset = 1'b0;

    // Pipeline write then idle.
    drive_cycle(1, 5'd4, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 0, acc, rdy);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, acc, rdy);

    // Idle pipe: mc accepted immediately.
    drive_cycle(0, 0, 0, 1, 5'd12, 64'hFEDC_BA98_7654_3210, 0, 0, acc, rdy);
    check_eq("idle_mc_acc", rdy, 1);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, acc, rdy);

    // Scoreboard: issue, simultaneous re-issue + clear, clear.
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, acc, rdy);
    drive_cycle(0, 0, 0, 1, 5'd7, 64'h77, 1, 5'd7, acc, rdy);
    drive_cycle(0, 0, 0, 1, 5'd7, 64'h78, 0, 0, acc, rdy);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, acc, rdy);

    // Zero register: mc and wb writes discarded, issue ignored.
    drive_cycle(0, 0, 0, 1, 5'd31, 64'h31, 0, 0, acc, rdy);
    drive_cycle(1, 5'd31, 64'h32, 0, 0, 0, 1, 5'd31, acc, rdy);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, acc, rdy);

    // Starvation: continuous pipeline writes against a held mc request.
    refusals = 0;
    acc = 0;
    for (int i = 0; i < 10 && !acc; i++) begin
      drive_cycle(1, reg_addr_t'(i + 1), 64'hA000 + 64'(i), 1, 5'd9, 64'h9999, 0, 0, acc, rdy);
      if (!rdy) refusals++;
    end
    check_eq("starve_refusals", 64'(refusals), 64'(LIMIT));
    check_eq("starve_acc", acc, 1);
    drive_cycle(1, 5'd2, 64'hB002, 0, 0, 0, 0, 0, acc, rdy);
    drive_cycle(1, 5'd3, 64'hB003, 0, 0, 0, 0, 0, acc, rdy);

    // Random traffic honouring the hold-until-ready rule.
    mreq = 0; ma = '0; md = '0;
    for (int i = 0; i < 60; i++) begin
      if (!mreq && ($urandom_range(0, 2) == 0)) begin
        mreq = 1;
        ma = reg_addr_t'($urandom_range(0, 31));
        md = {$urandom, $urandom};
      end
      wa = reg_addr_t'($urandom_range(0, 31));
      ia = reg_addr_t'($urandom_range(0, 31));
      r1 = reg_addr_t'($urandom_range(0, 31));
      r2 = reg_addr_t'($urandom_range(0, 31));
      drive_cycle(1'($urandom_range(0, 3) != 0), wa, {$urandom, $urandom},
                  mreq, ma, md, !pend[ia] && ($urandom_range(0, 3) == 0), ia, acc, rdy);
      if (acc) mreq = 0;
    end
    if (mreq) begin
      for (int i = 0; i < 8 && mreq; i++) begin
        drive_cycle(0, 0, 0, 1, ma, md, 0, 0, acc, rdy);
        if (acc) mreq = 0;
      end
    end

    // Reset while in FORCE, with ra1=7 pending.
    r1 = 5'd7;
    r2 = 5'd31;
    if (!pend[7]) drive_cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, acc, rdy);
    for (int i = 0; i < 10 && !m_force; i++)
      drive_cycle(1, 5'd5, 64'hC000 + 64'(i), 1, 5'd20, 64'h2020, 0, 0, acc, rdy);
    bus.wb_valid = 1; bus.wb_addr = 5'd6; bus.wb_data = 64'hD;
    bus.mc_valid = 1; bus.mc_addr = 5'd20; bus.mc_data = 64'h2020;
    bus.ra1 = r1;
    #2;
    check_eq("pre_rst_stall", bus.stall_pipe, 1);
    check_eq("pre_rst_we3", bus.we3, 1);
    check_eq("pre_rst_busy1", bus.busy1, exp_busy(5'd7));
    reset = 1'b1;
    #1;
    check_eq("mid_rst_stall", bus.stall_pipe, 0);
    check_eq("mid_rst_we3", bus.we3, 0);
    check_eq("mid_rst_busy1", bus.busy1, 0);
    check_eq("mid_rst_ready", bus.mc_ready, 0);
    bus.wb_valid = 0;
    bus.mc_valid = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Arbitration after reset: mc re-presented on idle pipe.
    drive_cycle(0, 0, 0, 1, 5'd20, 64'h2020, 0, 0, acc, rdy);
    drive_cycle(1, 5'd8, 64'h8888, 0, 0, 0, 0, 0, acc, rdy);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, acc, rdy);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1);
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Arbitrates the single register-file write port (we3/wa3/wd3) between two writeback sources.
- Pipeline WB stage: priority requester, never back-pressured directly.
- Multi-cycle unit (divider / long-latency load): valid/ready requester.
- Anti-starvation: an age counter forces one pipeline stall cycle so the multi-cycle unit can commit.
- Scoreboard of pending long-latency destinations feeds the hazard unit.
- Sits between the WB stage / multi-cycle unit and regfile.

Parameters:
DATA_W, 64, register data width
ADDR_W, 5, register address width
NREG, 32, number of architectural registers
ZERO_REG, 31, hardwired-zero register index (XZR); writes to it are discarded
STARVE_LIMIT, 4, consecutive refused cycles of mc request before forced grant (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
wb_valid  in  1  pipeline writeback request
wb_addr  in  ADDR_W  pipeline destination register
wb_data  in  DATA_W  pipeline writeback data
mc_valid  in  1  multi-cycle unit writeback request
mc_addr  in  ADDR_W  multi-cycle destination register
mc_data  in  DATA_W  multi-cycle writeback data
mc_ready  out  1  multi-cycle request accepted this cycle
issue_valid  in  1  long-latency op issued; mark destination pending
issue_addr  in  ADDR_W  destination of issued op
ra1  in  ADDR_W  hazard lookup address 1
ra2  in  ADDR_W  hazard lookup address 2
busy1  out  1  pending[ra1]
busy2  out  1  pending[ra2]
stall_pipe  out  1  pipeline must hold WB stage this cycle
we3  out  1  regfile write enable (registered)
wa3  out  ADDR_W  regfile write address (registered)
wd3  out  DATA_W  regfile write data (registered)

Behaviour:
- Reset (async, any cycle incl. mid-handshake):
  - Outputs: we3=0, wa3=0, wd3=0, stall_pipe=0.
  - State: pending=0, wait_cnt=0, FSM=ARB.
  - In-flight mc request is dropped; the unit re-presents it after reset.
- FSM state ARB: stall_pipe=0, mc_ready = !wb_valid.
  - Pipeline grant: wb_valid=1 -> wb request granted.
  - Multi-cycle grant: wb_valid=0 and mc_valid=1 -> mc request granted (handshake).
- Starvation counting:
  - wait_cnt increments each cycle mc_valid && !mc_ready; clears on any mc handshake.
  - Width $clog2(STARVE_LIMIT+1); saturates, never wraps.
  - When wait_cnt==STARVE_LIMIT, next state is FORCE.
- FSM state FORCE: stall_pipe=1 (decoded from state), mc_ready=1.
  - Pipeline holds its WB instruction; wb_valid ignored and re-presented next cycle.
  - Next state ARB, wait_cnt=0.
- Handshake rule: mc_valid, once high, holds with stable addr/data until mc_ready. FORCE therefore always completes in one cycle.
- Write path, one-cycle latency:
  - Granted request registers into wa3/wd3 at the next edge.
  - we3=1 except when the granted address==ZERO_REG: we3=0 for a ZERO_REG write; handshake still completes.
  - No grant -> we3=0; wa3/wd3 hold.
- Same address on wb and mc in the same cycle: wb first, mc later. WAW ordering is the hazard unit's job via busy.
- Scoreboard:
  - issue_valid sets pending[issue_addr]; ignored for ZERO_REG.
  - mc handshake clears pending[mc_addr].
  - Set and clear of the same index in one cycle -> set wins.
  - busy1/busy2 are combinational reads of the registered pending vector. An issue becomes visible the cycle after issue_valid.
  - issue_valid to an already-pending address is illegal; simulation assertion.

Optional Feature:
REGFILE_WB_ARB_SCOREBOARD_EN
- Defined: pending vector, busy1/busy2 as above.
- Undefined: no pending storage; busy1=busy2=0; issue_valid/issue_addr/ra1/ra2 unused. Arbitration unchanged.

Decomposition:
- Package regfile_pkg:
  - DATA_W, ADDR_W, NREG, ZERO_REG constants.
  - typedef reg_addr_t, reg_data_t.
  - enum arb_state_t {ARB, FORCE}.
- Sub-module regfile_scoreboard: pending vector, set/clear, two lookup ports. Instantiated only under the macro.

Test Plan:
1. Reset mid-operation: reset pulsed while FSM=FORCE -> same cycle stall_pipe=0, we3=0, busy1=0 for ra1=7 previously pending.
2. Pipeline write: wb_valid=1, wb_addr=4, wb_data=64'h0123_4567_89AB_CDEF -> next cycle we3=1, wa3=4, wd3=64'h0123_4567_89AB_CDEF; following idle cycle we3=0.
3. Starvation: wb_valid=1 every cycle, mc_valid=1, mc_addr=9, STARVE_LIMIT=4 -> mc_ready=0 for 4 cycles; 5th cycle stall_pipe=1, mc_ready=1; next cycle we3=1, wa3=9; then stall_pipe=0 and wb writes resume.
4. Idle pipe: wb_valid=0, mc_valid=1, mc_addr=12, mc_data=64'hFEDC_BA98_7654_3210 -> mc_ready=1 same cycle; next cycle we3=1, wa3=12.
5. Zero register: mc write to addr 31 while pending[31]=0 and wb write to 31 -> handshakes complete, we3=0 both times; issue_valid to 31 leaves busy=0.
6. Scoreboard (macro on), all steps with ra1=7:
   - Issue addr 7 -> busy1=1 the next cycle.
   - mc handshake on 7 -> busy1=0 the next cycle.
   - Simultaneous issue 7 + mc clear 7 -> busy1 stays 1.
